addsub: RTL and testbench
=========================

ADDSUB -- requirements
Module: addsub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 a  input  WIDTH  first operand (minuend when subtracting).
REQ-005 b  input  WIDTH  second operand (subtrahend when subtracting).
REQ-006 sub  input  1  operation select: 0 = a+b, 1 = a-b.
REQ-007 sum  output  WIDTH  registered result, modulo 2^WIDTH.
REQ-008 carry  output  1  registered carry-out of the internal adder; for sub=1, 1 = no borrow.
REQ-009 overflow  output  1  registered two's-complement signed overflow.
REQ-010 zero  output  1  registered, 1 when sum is all zeros.
REQ-011 negative  output  1  registered copy of sum[WIDTH-1].

Function
REQ-012 The block SHALL compute a + (b XOR {WIDTH{sub}}) + sub, i.e. a+b for sub=0 and a+~b+1 for sub=1.
REQ-013 All operands SHALL be treated as unsigned bit vectors for sum and carry, and as two's-complement for overflow and negative.
REQ-014 Inputs a, b and sub SHALL be sampled on every rising clk edge; the result SHALL appear on the outputs after exactly 1 cycle, with no handshake and no stall.
REQ-015 Every input change SHALL be honoured independently; changing only a, only b or only sub SHALL update the result on the next edge.
REQ-016 sum SHALL wrap modulo 2^WIDTH; no saturation.
REQ-017 carry SHALL equal bit WIDTH of the (WIDTH+1)-bit internal sum; for sub=1, carry=1 iff a >= b unsigned.
REQ-018 overflow SHALL be 1 iff both adder inputs (a and the conditionally inverted b) have the same sign and sum's sign differs from it.
REQ-019 The adder SHALL be built as a carry-lookahead chain of 4-bit groups (WIDTH a multiple of 4); the group carry-out of the final group is carry.
REQ-020 Outputs SHALL be undefined-free after the first post-reset edge that samples known inputs; X inputs before then need not be masked.

Reset
REQ-021 While rst=1, sum, carry, overflow, negative SHALL be 0 and zero SHALL be 1, asynchronously, independent of clk.
REQ-022 Assertion of rst mid-operation SHALL discard any in-flight result; the first result after deassertion SHALL come from inputs sampled on the first rising edge with rst=0.

Structure
REQ-023 A shared package addsub_pkg SHALL hold the default WIDTH constant (32) and the group size constant (4).
REQ-024 One sub-module cla4 SHALL implement a 4-bit carry-lookahead group (inputs x, y, cin; outputs s, group propagate, group generate, cout); addsub instantiates WIDTH/4 of them plus the result register.

Verification
REQ-025 a=FFFFFFFF, b=FFFFFFFF, sub=0 -> next cycle sum=FFFFFFFE, carry=1, overflow=0, negative=1, zero=0.
REQ-026 a=FFFFFFFF, b=FFFFFFFF, sub=1 -> sum=00000000, carry=1, overflow=0, zero=1; a=0, b=0, sub=1 -> sum=0, carry=1, zero=1.
REQ-027 a=00000000, b=00000001, sub=1 -> sum=FFFFFFFF, carry=0, negative=1; a=7FFFFFFF, b=1, sub=0 -> sum=80000000, overflow=1.
REQ-028 Sweep i=0..127 with a=i, b=i mod 17, sub=i mod 2, changing one input per cycle -> every cycle sum equals a+b or a-b modulo 2^32 of the previous cycle's inputs, flags matching a reference model.
REQ-029 Assert rst asynchronously between edges while a=5, b=3, sub=0 -> outputs immediately sum=0, zero=1; deassert -> next edge sum=00000008.

Source files
------------

// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - shared constants for the registered add/subtract unit
package addsub_pkg;

  // Default operand/result width of addsub.
  localparam int DEFAULT_WIDTH = 32;

  // Bits per carry-lookahead group; WIDTH must be a multiple of this.
  localparam int GROUP_SIZE = 4;

endpackage

// File: rtl/addsub_cla4.sv
// rtl/addsub_cla4.sv - 4-bit carry-lookahead group with group propagate/generate
module cla4 (
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       cin,
  output logic [3:0] s,
  output logic       gp,
  output logic       gg,
  output logic       cout
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  // Bit propagate/generate, internal lookahead carries and group terms.
  always_comb begin
    p    = x ^ y;
    g    = x & y;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    gp   = &p;
    gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    cout = gg | (gp & cin);
    s    = p ^ c;
  end

endmodule

// File: rtl/addsub.sv
// rtl/addsub.sv - registered WIDTH-bit adder/subtractor with carry, overflow, zero, negative flags
module addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int GROUPS = WIDTH / GROUP_SIZE;

  logic [WIDTH-1:0]  b_eff;
  logic [WIDTH-1:0]  sum_next;
  logic [GROUPS:0]   c;
  logic [GROUPS-1:0] gp;
  logic [GROUPS-1:0] gg;
  logic [GROUPS-1:0] cout;
  logic              carry_next;
  logic              overflow_next;
  logic              unused_lookahead;

  // Subtraction is a + ~b + 1: invert b and feed sub in as the carry-in.
  assign b_eff = b ^ {WIDTH{sub}};
  assign c[0]  = sub;

  // Group chain: carries between groups come from the group propagate/generate terms.
  for (genvar gi = 0; gi < GROUPS; gi++) begin : g_group
    cla4 u_cla4 (
      .x    (a[gi*GROUP_SIZE +: GROUP_SIZE]),
      .y    (b_eff[gi*GROUP_SIZE +: GROUP_SIZE]),
      .cin  (c[gi]),
      .s    (sum_next[gi*GROUP_SIZE +: GROUP_SIZE]),
      .gp   (gp[gi]),
      .gg   (gg[gi]),
      .cout (cout[gi])
    );
    assign c[gi+1] = gg[gi] | (gp[gi] & c[gi]);
  end

  // The final group's own carry-out is the reported carry; the other group
  // carry-outs duplicate the lookahead carries and are deliberately unused.
  assign carry_next       = cout[GROUPS-1];
  assign unused_lookahead = c[GROUPS] ^ (^cout);

  // Signed overflow: both adder inputs share a sign and the result sign differs.
  assign overflow_next = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_next[WIDTH-1] != a[WIDTH-1]);

  // Result register; reset forces a clean zero result with the zero flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      zero     <= 1'b1;
      negative <= 1'b0;
    end else begin
      sum      <= sum_next;
      carry    <= carry_next;
      overflow <= overflow_next;
      zero     <= (sum_next == '0);
      negative <= sum_next[WIDTH-1];
    end
  end

endmodule

// File: tb/tb_addsub.sv
// tb/tb_addsub.sv - self-checking bench for addsub against an arithmetic reference model
module tb_addsub;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic        sub;
  logic [31:0] sum;
  logic        carry;
  logic        overflow;
  logic        zero;
  logic        negative;

  int checks;
  int errors;

  addsub #(.WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .sum      (sum),
    .carry    (carry),
    .overflow (overflow),
    .zero     (zero),
    .negative (negative)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {sum, carry, overflow, zero, negative} from plain integer arithmetic.
  function automatic logic [35:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [32:0] wide;
    logic [31:0] r;
    logic        c;
    logic        v;
    longint      sx;
    longint      sy;
    longint      sr;
    sx = longint'(signed'(x));
    sy = longint'(signed'(y));
    if (!s) begin
      wide = {1'b0, x} + {1'b0, y};
      r    = wide[31:0];
      c    = wide[32];
      sr   = sx + sy;
    end else begin
      r  = x - y;
      c  = (x >= y);
      sr = sx - sy;
    end
    v = (sr > SMAX) || (sr < SMIN);
    return {r, c, v, (r == 32'd0), r[31]};
  endfunction

  function automatic logic [35:0] observed();
    return {sum, carry, overflow, zero, negative};
  endfunction

  task automatic test_reset();
    logic [35:0] got;
    #1;
    got = observed();
    checks++;
    if (got !== {32'd0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: got %h required %h", got, {32'd0, 4'b0010});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_corners();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic        vs [6];
    logic [35:0] req [6];
    logic [35:0] got;
    va[0] = 32'hFFFFFFFF; vb[0] = 32'hFFFFFFFF; vs[0] = 1'b0; req[0] = {32'hFFFFFFFE, 4'b1001};
    va[1] = 32'hFFFFFFFF; vb[1] = 32'hFFFFFFFF; vs[1] = 1'b1; req[1] = {32'h00000000, 4'b1010};
    va[2] = 32'h00000000; vb[2] = 32'h00000000; vs[2] = 1'b1; req[2] = {32'h00000000, 4'b1010};
    va[3] = 32'h00000000; vb[3] = 32'h00000001; vs[3] = 1'b1; req[3] = {32'hFFFFFFFF, 4'b0001};
    va[4] = 32'h7FFFFFFF; vb[4] = 32'h00000001; vs[4] = 1'b0; req[4] = {32'h80000000, 4'b0101};
    va[5] = 32'h00000000; vb[5] = 32'h80000000; vs[5] = 1'b1; req[5] = {32'h80000000, 4'b0101};
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      a = va[i]; b = vb[i]; sub = vs[i];
      @(posedge clk);
      #1;
      got = observed();
      checks++;
      if (got !== req[i]) begin
        errors++;
        $display("FAIL corner_%0d: got %h required %h", i, got, req[i]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [35:0] exp;
    logic [35:0] got;
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      a = 32'(i); b = 32'(i % 17); sub = 1'(i % 2);
      exp = model(a, b, sub);
      @(posedge clk);
      #1;
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL sweep_%0d: got %h required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_single_input_change();
    logic [35:0] exp;
    logic [35:0] got;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      case (i % 3)
        0:       a = $urandom;
        1:       b = $urandom;
        default: sub = ~sub;
      endcase
      exp = model(a, b, sub);
      @(posedge clk);
      #1;
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_change_%0d: got %h required %h", i, got, exp);
      end
    end
  endtask

  task automatic test_back_to_back_random();
    logic [35:0] exp;
    logic [35:0] got;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      a   = ($urandom_range(0, 7) == 0) ? {$urandom_range(0, 1) ? 1'b1 : 1'b0, 31'h7FFFFFFF} : $urandom;
      b   = ($urandom_range(0, 7) == 0) ? a : $urandom;
      sub = 1'($urandom_range(0, 1));
      exp = model(a, b, sub);
      @(posedge clk);
      #1;
      got = observed();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_%0d: a=%h b=%h sub=%b got %h required %h", i, a, b, sub, got, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [35:0] got;
    @(negedge clk);
    a = 32'd5; b = 32'd3; sub = 1'b0;
    @(posedge clk);
    #1;
    got = observed();
    checks++;
    if (got !== {32'd8, 4'b0000}) begin
      errors++;
      $display("FAIL pre_reset_result: got %h required %h", got, {32'd8, 4'b0000});
    end
    #2;
    rst = 1'b1;
    #1;
    got = observed();
    checks++;
    if (got !== {32'd0, 4'b0010}) begin
      errors++;
      $display("FAIL async_reset_immediate: got %h required %h", got, {32'd0, 4'b0010});
    end
    @(posedge clk);
    #1;
    got = observed();
    checks++;
    if (got !== {32'd0, 4'b0010}) begin
      errors++;
      $display("FAIL reset_held_over_edge: got %h required %h", got, {32'd0, 4'b0010});
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    got = observed();
    checks++;
    if (got !== {32'd8, 4'b0000}) begin
      errors++;
      $display("FAIL first_after_reset: got %h required %h", got, {32'd8, 4'b0000});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst    = 1'b1;
    a      = '0;
    b      = '0;
    sub    = 1'b0;
    test_reset();
    test_corners();
    test_sweep();
    test_single_input_change();
    test_back_to_back_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
